// File: rtl/cpu_run_monitor.sv
// Run controller for the single-cycle cpu: sequences a run, counts cycles
// and branches, detects program end and scoreboards data-memory writes.
module cpu_run_monitor #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int CNT_WIDTH   = 16,
  parameter int MAX_CYCLES  = 1000,
  parameter int STALL_LIMIT = 8,
  parameter int NUM_CHECKS  = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [ADDR_WIDTH-1:0]            pc,
  input  logic                             halt,
  input  logic                             branch_taken,
  input  logic                             dmem_we,
  input  logic [ADDR_WIDTH-1:0]            dmem_addr,
  input  logic [DATA_WIDTH-1:0]            dmem_wdata,
  input  logic [NUM_CHECKS-1:0]            check_en,
  input  logic [NUM_CHECKS*ADDR_WIDTH-1:0] check_addr,
  input  logic [NUM_CHECKS*DATA_WIDTH-1:0] check_val,
  output logic                             running,
  output logic                             done,
  output logic                             timeout,
  output logic                             pass,
  output logic [CNT_WIDTH-1:0]             cycle_count,
  output logic [CNT_WIDTH-1:0]             branch_count,
  output logic [NUM_CHECKS-1:0]            check_hit
);

  localparam int SW = $clog2(STALL_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_n;
  logic                  begin_run, end_run, end_to;
  logic [CNT_WIDTH-1:0]  cyc_n, br_n;
  logic [31:0]           cyc_plus;
  logic [SW-1:0]         stall, stall_n;
  logic [ADDR_WIDTH-1:0] last_pc;
  logic [DATA_WIDTH-1:0] capture [NUM_CHECKS];
  logic [DATA_WIDTH-1:0] cap_n   [NUM_CHECKS];
  logic [NUM_CHECKS-1:0] hit_n;
  logic                  ok;

  assign running = (state == RUN);
  assign done    = (state == DONE);

  always_comb begin
    cyc_n    = (&cycle_count) ? cycle_count : cycle_count + 1'b1;
    br_n     = (branch_taken && !(&branch_count))
             ? branch_count + 1'b1 : branch_count;
    cyc_plus = 32'(cycle_count) + 32'd1;
    stall_n  = (pc == last_pc) ? stall + 1'b1 : '0;
    hit_n    = check_hit;
    ok       = 1'b1;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      cap_n[i] = capture[i];
      if (dmem_we && check_en[i] &&
          dmem_addr == check_addr[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        cap_n[i] = dmem_wdata;
        hit_n[i] = 1'b1;
      end
      // pass looks at the post-edge capture so the final write counts
      if (check_en[i] &&
          !(hit_n[i] && cap_n[i] == check_val[i*DATA_WIDTH +: DATA_WIDTH]))
        ok = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    begin_run = 1'b0;
    end_run   = 1'b0;
    end_to    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n   = RUN;
          begin_run = 1'b1;
        end
      end
      RUN: begin
        if (halt || stall_n == SW'(STALL_LIMIT)) begin
          end_run = 1'b1;
        end else if (cyc_plus == 32'(MAX_CYCLES)) begin
          end_run = 1'b1;
          end_to  = 1'b1;
        end
        if (end_run) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count  <= '0;
      branch_count <= '0;
      stall        <= '0;
      last_pc      <= '0;
      check_hit    <= '0;
      timeout      <= 1'b0;
      pass         <= 1'b0;
      for (int i = 0; i < NUM_CHECKS; i++) capture[i] <= '0;
    end else if (begin_run) begin
      cycle_count  <= '0;
      branch_count <= '0;
      stall        <= '0;
      last_pc      <= pc;
      check_hit    <= '0;
      timeout      <= 1'b0;
      pass         <= 1'b0;
      for (int i = 0; i < NUM_CHECKS; i++) capture[i] <= '0;
    end else if (state == RUN) begin
      cycle_count  <= cyc_n;
      branch_count <= br_n;
      stall        <= stall_n;
      last_pc      <= pc;
      check_hit    <= hit_n;
      for (int i = 0; i < NUM_CHECKS; i++) capture[i] <= cap_n[i];
      if (end_run) begin
        timeout <= end_to;
        pass    <= !end_to && ok;
      end
    end
  end

endmodule
